// File: rtl/commit_trace_buffer.sv
// Circular trace buffer for retired-instruction commit records.
// An arm/trigger FSM gates capture, and records drain over a valid/ready port.
module commit_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              commit_valid,
    input  logic [31:0]       commit_pc,
    input  logic [31:0]       commit_instr,
    input  logic [31:0]       commit_next_pc,
    input  logic [4:0]        commit_rd,
    input  logic [31:0]       commit_rd_data,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_en,
    input  logic [31:0]       trigger_pc,
    input  logic [15:0]       capture_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_seq,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_next_pc,
    output logic [31:0]       out_rd_data,
    output logic [4:0]        out_rd,
    output logic [1:0]        state,
    output logic [PTR_W:0]    count,
    output logic [15:0]       drop_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_ARMED   = 2'b01;
    localparam logic [1:0] ST_CAPTURE = 2'b10;
    localparam logic [1:0] ST_DONE    = 2'b11;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef struct packed {
        logic [15:0] seq;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] next_pc;
        logic [4:0]  rd;
        logic [31:0] rd_data;
    } rec_t;

    rec_t mem_q [DEPTH];

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [15:0]      seq_q, seq_d;
    logic [15:0]      drop_q, drop_d;

    logic cap;
    logic pop;
    logic push_ok;
    logic last_evt;
    rec_t wr_rec;
    rec_t head;

    always_comb begin
        cap     = 1'b0;
        state_d = state_q;
        seq_d   = seq_q;
        drop_d  = drop_q;

        // arm/abort win over a same-cycle commit, so that commit is never recorded
        if (abort) begin
            state_d = ST_IDLE;
        end else if (arm) begin
            state_d = trig_en ? ST_ARMED : ST_CAPTURE;
            seq_d   = 16'd0;
            drop_d  = 16'd0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (commit_valid && (commit_pc == trigger_pc)) begin
                        cap     = 1'b1;
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: cap = commit_valid;
                default:    cap = 1'b0;
            endcase
        end

        last_evt = (capture_len != 16'd0) && (seq_q == capture_len - 16'd1);
        if (cap && last_evt) begin
            state_d = ST_DONE;
        end
        if (cap) begin
            seq_d = seq_q + 16'd1;
        end

        pop     = out_valid && out_ready;
        push_ok = cap && ((count_q != FULL_CNT) || pop);
        if (cap && !push_ok && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push_ok) begin
            count_d = count_q - CNT_ONE;
        end

        wr_rec.seq     = seq_q;
        wr_rec.pc      = commit_pc;
        wr_rec.instr   = commit_instr;
        wr_rec.next_pc = commit_next_pc;
        wr_rec.rd      = commit_rd;
        wr_rec.rd_data = (commit_rd == 5'd0) ? 32'd0 : commit_rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= 16'd0;
            drop_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is not reset; the outputs are masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_rec;
        end
    end

    assign out_valid   = (count_q != '0);
    assign head        = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_seq     = head.seq;
    assign out_pc      = head.pc;
    assign out_instr   = head.instr;
    assign out_next_pc = head.next_pc;
    assign out_rd      = head.rd;
    assign out_rd_data = head.rd_data;
    assign state       = state_q;
    assign count       = count_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed scenarios plus random
// traffic, all compared every cycle against a queue-based reference model.
module tb_commit_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        commit_valid;
    logic [31:0] commit_pc, commit_instr, commit_next_pc, commit_rd_data;
    logic [4:0]  commit_rd;
    logic        arm, abort, trig_en;
    logic [31:0] trigger_pc;
    logic [15:0] capture_len;
    logic        out_valid, out_ready;
    logic [15:0] out_seq;
    logic [31:0] out_pc, out_instr, out_next_pc, out_rd_data;
    logic [4:0]  out_rd;
    logic [1:0]  state;
    logic [4:0]  count;
    logic [15:0] drop_cnt;

    commit_trace_buffer #(.DEPTH(16), .PTR_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
        .commit_next_pc(commit_next_pc), .commit_rd(commit_rd), .commit_rd_data(commit_rd_data),
        .arm(arm), .abort(abort), .trig_en(trig_en), .trigger_pc(trigger_pc),
        .capture_len(capture_len), .out_valid(out_valid), .out_ready(out_ready),
        .out_seq(out_seq), .out_pc(out_pc), .out_instr(out_instr), .out_next_pc(out_next_pc),
        .out_rd_data(out_rd_data), .out_rd(out_rd), .state(state), .count(count),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          seq;
        logic [31:0] pc, instr, npc, rdd;
        logic [4:0]  rd;
    } rec_t;

    // Model: 0 idle, 1 armed, 2 capture, 3 done
    rec_t mq[$];
    int   ms, mseq, mdrop;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        ms = 0; mseq = 0; mdrop = 0;
    endtask

    task automatic compare_all();
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("count", 32'(count), 32'(mq.size()));
        chk("state", 32'(state), 32'(ms));
        chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
        if (mq.size() != 0) begin
            chk("out_seq", 32'(out_seq), 32'(mq[0].seq));
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_instr", out_instr, mq[0].instr);
            chk("out_next_pc", out_next_pc, mq[0].npc);
            chk("out_rd", 32'(out_rd), 32'(mq[0].rd));
            chk("out_rd_data", out_rd_data, mq[0].rdd);
        end
    endtask

    // Applies the current inputs to the model, clocks the DUT, then compares.
    task automatic cyc();
        bit   pop, cap;
        rec_t r;
        pop = (mq.size() != 0) && out_ready;
        cap = 0;
        if (abort) ms = 0;
        else if (arm) begin
            ms = trig_en ? 1 : 2;
            mseq = 0; mdrop = 0;
        end else if (ms == 1 && commit_valid && commit_pc == trigger_pc) cap = 1;
        else if (ms == 2 && commit_valid) cap = 1;
        if (pop) void'(mq.pop_front());
        if (cap) begin
            ms = 2;
            if (capture_len != 0 && mseq == int'(capture_len) - 1) ms = 3;
            r.seq = mseq; r.pc = commit_pc; r.instr = commit_instr; r.npc = commit_next_pc;
            r.rd = commit_rd; r.rdd = (commit_rd == 0) ? 32'd0 : commit_rd_data;
            if (mq.size() < 16) mq.push_back(r);
            else if (mdrop < 16'hFFFF) mdrop++;
            mseq = (mseq + 1) & 16'hFFFF;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic commit(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] rdd);
        commit_valid = 1; commit_pc = pc; commit_instr = $urandom;
        commit_next_pc = pc + 32'd4; commit_rd = rd; commit_rd_data = rdd;
        cyc();
        commit_valid = 0;
    endtask

    task automatic pulse_arm();
        arm = 1; cyc(); arm = 0;
    endtask

    task automatic drain();
        out_ready = 1;
        for (int i = 0; i < 20 && mq.size() != 0; i++) cyc();
        chk("drain_empty", 32'(count), 32'd0);
    endtask

    initial begin
        rst_n = 0; commit_valid = 0; commit_pc = 0; commit_instr = 0; commit_next_pc = 0;
        commit_rd = 0; commit_rd_data = 0; arm = 0; abort = 0; trig_en = 0;
        trigger_pc = 0; capture_len = 0; out_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("reset_out_pc", out_pc, 32'd0);
        rst_n = 1;
        cyc();

        // Basic capture
        trig_en = 0; capture_len = 3; out_ready = 1;
        pulse_arm();
        commit(32'h60, 5'd1, 32'h11);
        commit(32'h64, 5'd2, 32'h22);
        commit(32'h68, 5'd3, 32'h33);
        chk("basic_done", 32'(state), 32'd3);
        commit(32'h6C, 5'd4, 32'h44);
        chk("basic_ignored", 32'(state), 32'd3);
        chk("basic_drop", 32'(drop_cnt), 32'd0);
        drain();

        // Trigger
        trig_en = 1; trigger_pc = 32'h80; capture_len = 0; out_ready = 0;
        pulse_arm();
        commit(32'h7C, 5'd1, 32'h1);
        chk("trig_armed", 32'(state), 32'd1);
        commit(32'h80, 5'd2, 32'h2);
        commit(32'h84, 5'd3, 32'h3);
        chk("trig_head_pc", out_pc, 32'h80);
        chk("trig_head_seq", 32'(out_seq), 32'd0);
        chk("trig_count", 32'(count), 32'd2);
        drain();

        // Overflow
        trig_en = 0; capture_len = 0; out_ready = 0;
        pulse_arm();
        for (int i = 0; i < 20; i++) commit(32'h200 + 32'(i * 4), 5'd5, 32'(i));
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_drop", 32'(drop_cnt), 32'd4);
        chk("ovf_head_seq", 32'(out_seq), 32'd0);
        out_ready = 1;
        commit(32'h300, 5'd6, 32'h77);
        chk("ovf_pushpop_count", 32'(count), 32'd16);
        chk("ovf_pushpop_drop", 32'(drop_cnt), 32'd4);
        drain();

        // Backpressure and rd0
        out_ready = 0;
        pulse_arm();
        commit(32'h400, 5'd0, 32'hDEAD);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_rd0", out_rd_data, 32'd0);
        end
        out_ready = 1;
        cyc();
        chk("bp_popped", 32'(count), 32'd0);

        // Abort, then asynchronous reset mid-drain
        out_ready = 0;
        pulse_arm();
        for (int i = 0; i < 3; i++) commit(32'h500 + 32'(i * 4), 5'd7, 32'(i));
        abort = 1; cyc(); abort = 0;
        chk("abort_idle", 32'(state), 32'd0);
        chk("abort_kept", 32'(count), 32'd3);
        out_ready = 1;
        cyc();
        #3 rst_n = 0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        compare_all();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            arm          = ($urandom_range(0, 19) == 0);
            abort        = ($urandom_range(0, 39) == 0);
            trig_en      = $urandom_range(0, 1);
            trigger_pc   = 32'h1000 + 32'($urandom_range(0, 2) * 4);
            capture_len  = 16'($urandom_range(0, 6));
            out_ready    = ($urandom_range(0, 2) == 0);
            commit_valid = $urandom_range(0, 1);
            commit_pc    = 32'h1000 + 32'($urandom_range(0, 2) * 4);
            commit_instr = $urandom;
            commit_next_pc = $urandom;
            commit_rd    = 5'($urandom_range(0, 3));
            commit_rd_data = $urandom;
            cyc();
        end
        arm = 0; abort = 0; commit_valid = 0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
